// File: rtl/iter_div_unit_if.sv
// Request/response bundle between issue, the divide unit and writeback.
// The master side issues operations and consumes results.
interface iter_div_unit_if #(
   parameter int p_seq_num_bits = 5
);
   logic                      req_val;
   logic                      req_rdy;
   logic [1:0]                req_op;
   logic [31:0]               req_op1;
   logic [31:0]               req_op2;
   logic [4:0]                req_waddr;
   logic [p_seq_num_bits-1:0] req_seq_num;
   logic                      resp_val;
   logic                      resp_rdy;
   logic [31:0]               resp_wdata;
   logic [4:0]                resp_waddr;
   logic [p_seq_num_bits-1:0] resp_seq_num;

   modport master (
      output req_val, req_op, req_op1, req_op2,
      output req_waddr, req_seq_num, resp_rdy,
      input  req_rdy, resp_val, resp_wdata,
      input  resp_waddr, resp_seq_num
   );

   modport slave (
      input  req_val, req_op, req_op1, req_op2,
      input  req_waddr, req_seq_num, resp_rdy,
      output req_rdy, resp_val, resp_wdata,
      output resp_waddr, resp_seq_num
   );
endinterface

// File: rtl/iter_div_unit.sv
// Iterative restoring divider for div/divu/rem/remu, one quotient
// bit per cycle, one operation in flight.
module iter_div_unit #(
   parameter int p_seq_num_bits = 5
) (
   input logic           clk,
   input logic           rst,
   iter_div_unit_if.slave io
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                    state_q, state_d;
   logic [1:0]                op_q;
   logic [4:0]                waddr_q;
   logic [p_seq_num_bits-1:0] seq_q;
   logic [31:0]               rem_q, dvd_q, dsr_q;
   logic [4:0]                cnt_q;
   logic                      q_neg_q, r_neg_q, dz_q, ovf_q;

   logic        accept, is_signed, is_rem;
   logic [31:0] op1_mag, op2_mag;
   logic [32:0] rem_sh, trial;
   logic [31:0] q_val, r_val, wdata;

   assign accept    = (state_q == IDLE) && io.req_val;
   assign is_signed = ~io.req_op[0];
   assign op1_mag   = (is_signed && io.req_op1[31]) ? -io.req_op1
                                                    : io.req_op1;
   assign op2_mag   = (is_signed && io.req_op2[31]) ? -io.req_op2
                                                    : io.req_op2;

   // Shift in the next dividend bit; remainder can briefly need 33 bits
   assign rem_sh = {rem_q, dvd_q[31]};
   assign trial  = rem_sh - {1'b0, dsr_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (io.req_val)    state_d = CALC;
         CALC:    if (cnt_q == 5'd0) state_d = DONE;
         DONE:    if (io.resp_rdy)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= '0;
         waddr_q <= '0;
         seq_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         cnt_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         op_q    <= io.req_op;
         waddr_q <= io.req_waddr;
         seq_q   <= io.req_seq_num;
         rem_q   <= '0;
         dvd_q   <= op1_mag;
         dsr_q   <= op2_mag;
         cnt_q   <= 5'd31;
         q_neg_q <= is_signed & (io.req_op1[31] ^ io.req_op2[31]);
         r_neg_q <= is_signed & io.req_op1[31];
         dz_q    <= (io.req_op2 == 32'd0);
         ovf_q   <= is_signed && (io.req_op1 == 32'h8000_0000)
                              && (io.req_op2 == 32'hFFFF_FFFF);
      end else if (state_q == CALC) begin
         rem_q <= trial[32] ? rem_sh[31:0] : trial[31:0];
         dvd_q <= {dvd_q[30:0], ~trial[32]};
         if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
      end
   end

   assign is_rem = op_q[1];
   assign q_val  = q_neg_q ? -dvd_q : dvd_q;
   assign r_val  = r_neg_q ? -rem_q : rem_q;

   // A zero divisor leaves |op1| in the remainder, so rem already yields op1
   always_comb begin
      wdata = q_val;
      unique case (1'b1)
         ovf_q && is_rem:          wdata = 32'd0;
         ovf_q && !is_rem:         wdata = 32'h8000_0000;
         dz_q && !is_rem:          wdata = 32'hFFFF_FFFF;
         !ovf_q && is_rem:         wdata = r_val;
         !ovf_q && !dz_q && !is_rem: wdata = q_val;
         default:                  wdata = q_val;
      endcase
   end

   assign io.req_rdy      = (state_q == IDLE);
   assign io.resp_val     = (state_q == DONE);
   assign io.resp_wdata   = wdata;
   assign io.resp_waddr   = waddr_q;
   assign io.resp_seq_num = seq_q;
endmodule
